icache: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/icache_if.sv | 23 ++
 rtl/icache_frames.sv | 49 ++++
 rtl/icache.sv | 100 ++++++++++
 tb/tb_icache.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: address decode, default geometry
// and the miss-handling state encoding.
package cpu_types_pkg;

    localparam int ICACHE_SETS = 16;
    localparam int ICACHE_IDX  = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG  = 30 - ICACHE_IDX;

    // Fetch address split for the default geometry
    typedef struct packed {
        logic [ICACHE_TAG-1:0] tag;
        logic [ICACHE_IDX-1:0] idx;
        logic [1:0]            bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction-side bundle: datapath fetch port plus memory-controller
// instruction port. The cache is the slave; the datapath/memory side is master.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    modport slave (
        input  imemREN, imemaddr, iflush, iload, iwait,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iload, iwait,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_frames.sv
// Frame storage for the direct-mapped instruction cache: valid bits, tags and
// one data word per frame. One write port, one combinational read port.
module icache_frames #(
    parameter int SETS  = 16,
    parameter int IDX   = $clog2(SETS),
    parameter int TAG_W = 30 - IDX
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             wen,
    input  logic [IDX-1:0]   widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata,
    input  logic [IDX-1:0]   ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      words [SETS];

    // Valid bits: async clear on reset; flush wins over a same-cycle fill so
    // a fill racing a flush never becomes visible
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wen) begin
            valid[widx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; they are qualified by valid
    always_ff @(posedge CLK) begin
        if (wen) begin
            tags[widx]  <= wtag;
            words[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = words[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache. Hits answer in the
// request cycle; a miss holds a single-word memory read until iwait drops.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  bus
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    icache_state_t    state, next_state;
    logic [29:0]      miss_word;
    logic [IDX-1:0]   req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             fr_valid;
    logic [TAG_W-1:0] fr_tag;
    logic [31:0]      fr_data;
    logic             hit;
    logic             fill;
    logic             latch_miss;
    logic             unused_bytoff;

    assign req_idx       = bus.imemaddr[IDX+1:2];
    assign req_tag       = bus.imemaddr[31:IDX+2];
    assign unused_bytoff = ^bus.imemaddr[1:0];
    assign hit           = bus.imemREN & fr_valid & (fr_tag == req_tag);

    icache_frames #(
        .SETS  (SETS),
        .IDX   (IDX),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK    (CLK),
        .nRST   (nRST),
        .flush  (bus.iflush),
        .wen    (fill),
        .widx   (miss_word[IDX-1:0]),
        .wtag   (miss_word[29:IDX]),
        .wdata  (bus.iload),
        .ridx   (req_idx),
        .rvalid (fr_valid),
        .rtag   (fr_tag),
        .rdata  (fr_data)
    );

    // State register; reset can land mid-FETCH and abandons the transaction
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Miss address (word granular) captured once on FETCH entry; the fill
    // uses only this, whatever the datapath does meanwhile
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_word <= '0;
        end else if (latch_miss) begin
            miss_word <= bus.imemaddr[31:2];
        end
    end

    // Next state and all port outputs
    always_comb begin
        next_state   = state;
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        fill         = 1'b0;
        latch_miss   = 1'b0;
        case (state)
            IDLE: begin
                bus.ihit     = hit;
                bus.imemload = hit ? fr_data : 32'h0;
                if (bus.imemREN && !hit && !bus.iflush) begin
                    latch_miss = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                bus.iREN  = 1'b1;
                bus.iaddr = {miss_word, 2'b00};
                if (!bus.iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: a line-level reference model checked every cycle on the
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_icache;
    import cpu_types_pkg::*;

    localparam int NSETS = 16;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    icache_if bus ();

    icache #(.SETS(NSETS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each line remembers which word address it holds.
    // A miss is an outstanding word address that completes when memory
    // stops waiting.
    logic        m_valid [NSETS];
    logic [29:0] m_line  [NSETS];
    logic [31:0] m_data  [NSETS];
    logic        m_busy;
    logic [31:0] m_addr;
    int          li;
    int          mi;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;

    always @(negedge CLK) begin
        if (!nRST) begin
            check("rst_ihit", {31'h0, bus.ihit}, 32'h0);
            check("rst_iREN", {31'h0, bus.iREN}, 32'h0);
            check("rst_iaddr", bus.iaddr, 32'h0);
            check("rst_imemload", bus.imemload, 32'h0);
            for (int k = 0; k < NSETS; k++) m_valid[k] = 1'b0;
            m_busy = 1'b0;
            m_addr = 32'h0;
        end else begin
            li = int'((bus.imemaddr / 4) % NSETS);
            e_hit = !m_busy && bus.imemREN && m_valid[li] && (m_line[li] == bus.imemaddr[31:2]);
            e_load  = e_hit ? m_data[li] : 32'h0;
            e_ren   = m_busy;
            e_iaddr = m_busy ? (m_addr / 4) * 4 : 32'h0;
            check("mdl_ihit", {31'h0, bus.ihit}, {31'h0, e_hit});
            check("mdl_imemload", bus.imemload, e_load);
            check("mdl_iREN", {31'h0, bus.iREN}, {31'h0, e_ren});
            check("mdl_iaddr", bus.iaddr, e_iaddr);
            // advance the model to what the coming edge does
            if (m_busy) begin
                if (!bus.iwait) begin
                    mi = int'((m_addr / 4) % NSETS);
                    if (!bus.iflush) begin
                        m_valid[mi] = 1'b1;
                        m_line[mi]  = m_addr[31:2];
                        m_data[mi]  = bus.iload;
                    end
                    m_busy = 1'b0;
                end
            end else if (bus.imemREN && !e_hit && !bus.iflush) begin
                m_busy = 1'b1;
                m_addr = bus.imemaddr;
            end
            if (bus.iflush) begin
                for (int k = 0; k < NSETS; k++) m_valid[k] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        icachef_t f;
        checks = 0;
        errors = 0;
        nRST = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iflush   = 1'b0;
        bus.iload    = 32'h0;
        bus.iwait    = 1'b1;

        // decode sanity for the default geometry used below
        f = icachef_t'(32'h0000_0044);
        check("decode_idx", {28'h0, f.idx}, 32'h1);
        check("decode_tag", {6'h0, f.tag}, 32'h1);

        // reset state
        tick(); tick();
        nRST = 1'b1;
        #1;
        check("reset_ihit", {31'h0, bus.ihit}, 32'h0);
        check("reset_iREN", {31'h0, bus.iREN}, 32'h0);
        check("reset_iaddr", bus.iaddr, 32'h0);
        check("reset_imemload", bus.imemload, 32'h0);

        // cold miss on 0x40 with two wait cycles
        tick(); bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b1; #1;
        check("miss0_ihit", {31'h0, bus.ihit}, 32'h0);
        check("miss0_iREN", {31'h0, bus.iREN}, 32'h0);
        tick(); #1;
        check("miss1_iREN", {31'h0, bus.iREN}, 32'h1);
        check("miss1_iaddr", bus.iaddr, 32'h40);
        check("miss1_ihit", {31'h0, bus.ihit}, 32'h0);
        tick(); #1;
        check("miss2_iREN", {31'h0, bus.iREN}, 32'h1);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h2001_0005; #1;
        check("miss3_iREN", {31'h0, bus.iREN}, 32'h1);
        check("miss3_iaddr", bus.iaddr, 32'h40);
        tick(); bus.iwait = 1'b1; #1;
        check("miss4_ihit", {31'h0, bus.ihit}, 32'h1);
        check("miss4_load", bus.imemload, 32'h2001_0005);
        check("miss4_iREN", {31'h0, bus.iREN}, 32'h0);

        // re-request hits with no memory traffic
        tick(); #1;
        check("rehit_ihit", {31'h0, bus.ihit}, 32'h1);
        check("rehit_iREN", {31'h0, bus.iREN}, 32'h0);

        // conflict: 0x80 shares index 0 with 0x40
        tick(); bus.imemaddr = 32'h80; #1;
        check("conf_ihit", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iwait = 1'b0; bus.iload = 32'hAAAA_0080; #1;
        check("conf_iaddr", bus.iaddr, 32'h80);
        tick(); bus.iwait = 1'b1; #1;
        check("conf_hit", {31'h0, bus.ihit}, 32'h1);
        check("conf_load", bus.imemload, 32'hAAAA_0080);
        tick(); bus.imemaddr = 32'h40; #1;
        check("conf_evict", {31'h0, bus.ihit}, 32'h0);

        // mid-FETCH the datapath moves away; the fill still targets 0x40
        tick(); bus.imemREN = 1'b0; bus.imemaddr = 32'h100; #1;
        check("mid_iaddr0", bus.iaddr, 32'h40);
        check("mid_iREN0", {31'h0, bus.iREN}, 32'h1);
        tick(); #1;
        check("mid_iaddr1", bus.iaddr, 32'h40);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h2001_0005; #1;
        check("mid_iaddr2", bus.iaddr, 32'h40);
        tick(); bus.iwait = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h40; #1;
        check("mid_fill_hit", {31'h0, bus.ihit}, 32'h1);
        check("mid_fill_load", bus.imemload, 32'h2001_0005);
        tick(); bus.imemaddr = 32'h100; #1;
        check("mid_100_miss", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.imemREN = 1'b0; bus.iwait = 1'b0; bus.iload = 32'h0100_0100; #1;
        check("f100_iaddr", bus.iaddr, 32'h100);
        tick(); bus.iwait = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h40; #1;
        check("f40_after_100", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h2001_0005;
        tick(); bus.iwait = 1'b1; #1;
        check("f40_back", {31'h0, bus.ihit}, 32'h1);

        // fill 0x44, then flush both
        tick(); bus.imemaddr = 32'h44; #1;
        check("f44_miss", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h4444_0044;
        tick(); bus.iwait = 1'b1; #1;
        check("f44_hit", {31'h0, bus.ihit}, 32'h1);
        check("f44_load", bus.imemload, 32'h4444_0044);
        tick(); bus.imemREN = 1'b0; bus.iflush = 1'b1; #1;
        check("flush_iREN", {31'h0, bus.iREN}, 32'h0);
        tick(); bus.iflush = 1'b0; bus.imemREN = 1'b1; bus.imemaddr = 32'h40; #1;
        check("flush_40_miss", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h2001_0005; #1;
        check("flush_40_iaddr", bus.iaddr, 32'h40);
        tick(); bus.iwait = 1'b1; bus.imemaddr = 32'h44; #1;
        check("flush_44_miss", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h4444_0044;
        tick(); bus.iwait = 1'b1; #1;
        check("f44_refill", {31'h0, bus.ihit}, 32'h1);

        // flush in IDLE blocks FETCH entry
        tick(); bus.imemaddr = 32'h48; bus.iflush = 1'b1; #1;
        check("blk_ihit", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iflush = 1'b0; bus.imemREN = 1'b0; #1;
        check("blk_iREN", {31'h0, bus.iREN}, 32'h0);

        // flush coinciding with the fill discards it
        tick(); bus.imemREN = 1'b1; bus.imemaddr = 32'h4C; #1;
        check("fd_miss", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iflush = 1'b1; bus.iwait = 1'b0; bus.iload = 32'h4C4C_004C; #1;
        check("fd_iREN", {31'h0, bus.iREN}, 32'h1);
        check("fd_iaddr", bus.iaddr, 32'h4C);
        tick(); bus.iflush = 1'b0; bus.iwait = 1'b1; #1;
        check("fd_discarded", {31'h0, bus.ihit}, 32'h0);
        tick(); bus.iwait = 1'b0;
        tick(); bus.iwait = 1'b1; #1;
        check("fd_refill", {31'h0, bus.ihit}, 32'h1);
        check("fd_refill_load", bus.imemload, 32'h4C4C_004C);

        // asynchronous reset mid-FETCH
        tick(); bus.imemaddr = 32'h50; #1;
        check("ar_miss", {31'h0, bus.ihit}, 32'h0);
        tick(); #1;
        check("ar_iREN_pre", {31'h0, bus.iREN}, 32'h1);
        check("ar_iaddr_pre", bus.iaddr, 32'h50);
        nRST = 1'b0; #1;
        check("ar_iREN", {31'h0, bus.iREN}, 32'h0);
        check("ar_iaddr", bus.iaddr, 32'h0);
        check("ar_ihit", {31'h0, bus.ihit}, 32'h0);
        tick(); tick();
        nRST = 1'b1; bus.imemaddr = 32'h4C; #1;
        check("ar_4C_miss", {31'h0, bus.ihit}, 32'h0);
        check("ar_4C_iREN", {31'h0, bus.iREN}, 32'h0);
        tick(); bus.iwait = 1'b0; bus.iload = 32'h4C4C_004C; #1;
        check("ar_4C_iaddr", bus.iaddr, 32'h4C);
        tick(); bus.iwait = 1'b1; #1;
        check("ar_4C_hit", {31'h0, bus.ihit}, 32'h1);

        tick(); bus.imemREN = 1'b0;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
